// File: rtl/serial_sub8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub8_pkg
// Purpose  : Shared definitions for the bit-serial 8-bit subtractor.
//            Holds the default operand width, the bit-counter width
//            derived from it, and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub8_pkg;

    // Default operand/result width.
    localparam int c_WIDTH = 8;

    // Bit counter width needed to index every bit of a c_WIDTH operand.
    localparam int c_CNT_W = $clog2(c_WIDTH);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub8_pkg
`default_nettype wire

// File: rtl/serial_sub8_fs.sv
`default_nettype none
// ============================================================================
// Module   : fs
// Purpose  : Single-bit full subtractor computing x - y - bin.
// Ports    : x    (in)  minuend bit
//            y    (in)  subtrahend bit
//            bin  (in)  borrow in
//            diff (out) difference bit
//            bout (out) borrow out
// Revision : 1.0 - initial release
// ============================================================================
module fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    // Borrow whenever the subtracted quantity (y + bin) exceeds x.
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : fs
`default_nettype wire

// File: rtl/serial_sub8.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub8
// Purpose  : Bit-serial subtractor. Computes a - b LSB-first, one bit per
//            clock, through a single full subtractor. Reports the modular
//            difference, unsigned borrow and two's-complement overflow.
// Ports    : clk   (in)  system clock, rising edge active
//            rst   (in)  asynchronous active-high reset
//            start (in)  begin a subtraction (sampled only while ready)
//            a     (in)  minuend, captured on the accepting edge
//            b     (in)  subtrahend, captured on the accepting edge
//            ready (out) idle, able to accept start
//            busy  (out) bits being processed
//            done  (out) one-cycle pulse, results valid
//            d     (out) difference a-b mod 2^WIDTH, held until next result
//            bout  (out) unsigned borrow out (a < b), held with d
//            ovfl  (out) signed overflow of a-b, held with d
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovfl
);

    localparam int                 c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]    c_LAST = c_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    // Collects the first WIDTH-1 difference bits; the final bit is merged
    // straight into the output register on the last shift edge.
    logic [WIDTH-2:0]  r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic              r_borrow;

    logic [WIDTH-1:0]  r_d;
    logic              r_bout;
    logic              r_ovfl;

    logic              w_diff;
    logic              w_bnext;

    fs u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bnext)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_ovfl   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (busy) begin
            // Operands shift right so bit[counter] is always at position 0.
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_acc    <= {w_diff, r_acc[WIDTH-2:1]};
            r_borrow <= w_bnext;
            r_cnt    <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_d    <= {w_diff, r_acc};
                r_bout <= w_bnext;
                // Signed overflow: carry into the sign bit differs from
                // carry out of it.
                r_ovfl <= r_borrow ^ w_bnext;
            end
        end
    end

    assign d    = r_d;
    assign bout = r_bout;
    assign ovfl = r_ovfl;

endmodule : serial_sub8
`default_nettype wire

// File: tb/tb_serial_sub8.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub8
// Purpose  : Self-checking bench for serial_sub8 using an expected-result
//            queue filled at stimulus time and drained at each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub8;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovfl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       ovfl;

    int   n_cmp;
    int   n_err;
    int   done_count;
    exp_t sb_q[$];

    serial_sub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovfl  (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count = done_count + 1;
    end

    // Reference: 9-bit subtraction gives borrow; overflow when operand signs
    // differ and the result sign differs from the minuend sign.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t       r;
        logic [8:0] full;
        full   = {1'b0, x} - {1'b0, y};
        r.d    = full[7:0];
        r.bout = full[8];
        r.ovfl = (x[7] ^ y[7]) & (r.d[7] ^ x[7]);
        return r;
    endfunction

    // Launch one operation, check latency and the popped expectation.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string tag);
        exp_t e;
        int   edges;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back(model(x, y));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = x ^ y;
        edges = 1;
        while (done !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1) edges++;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (edges != 8) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges after accept, expected 8", tag, edges);
        end
        n_cmp++;
        if ({d, bout, ovfl} !== {e.d, e.bout, e.ovfl}) begin
            n_err++;
            $display("FAIL %s result: got d=%h bout=%b ovfl=%b, expected d=%h bout=%b ovfl=%b",
                     tag, d, bout, ovfl, e.d, e.bout, e.ovfl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL %s flags: got ready/busy/done=%b%b%b, expected 100", tag, ready, busy, done);
        end
        n_cmp++;
        if ({d, bout, ovfl} !== 10'd0) begin
            n_err++;
            $display("FAIL %s outputs: got d=%h bout=%b ovfl=%b, expected all 0", tag, d, bout, ovfl);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #3;
        check_idle_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03, "sub_05_03");
        run_op(8'h03, 8'h05, "sub_03_05");
        run_op(8'h80, 8'h01, "ovf_80_01");
        run_op(8'h7F, 8'hFF, "ovf_7F_FF");
        run_op(8'h00, 8'h00, "zero");
        run_op(8'hFF, 8'hFF, "equal_FF");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
        end
    endtask

    task automatic test_start_while_busy();
        int   c0;
        int   edges;
        exp_t e;
        c0 = done_count;
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        sb_q.push_back(model(8'h10, 8'h01));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_flag: got busy=%b ready=%b, expected busy=1 ready=0", busy, ready);
        end
        repeat (2) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if ({d, bout, ovfl} !== {e.d, e.bout, e.ovfl} || done !== 1'b1) begin
            n_err++;
            $display("FAIL busy_result: got done=%b d=%h bout=%b ovfl=%b, expected done=1 d=%h bout=%b ovfl=%b",
                     done, d, bout, ovfl, e.d, e.bout, e.ovfl);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ready_in_done: got ready=%b, expected 0", ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL busy_ready_return: got ready/busy/done=%b%b%b, expected 100", ready, busy, done);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (done_count - c0 != 1) begin
            n_err++;
            $display("FAIL busy_single_done: got %0d done pulses, expected 1", done_count - c0);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c0 = done_count;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if (done_count != c0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", done_count - c0);
        end
        run_op(8'h00, 8'h00, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        exp_t       e;
        int         last;
        int         got;
        int         pushed;
        va = '{8'h12, 8'h80, 8'h01, 8'hC3};
        vb = '{8'h34, 8'h7F, 8'h02, 8'h3C};
        last   = -1;
        got    = 0;
        pushed = 0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({d, bout, ovfl} !== {e.d, e.bout, e.ovfl}) begin
                    n_err++;
                    $display("FAIL b2b_result: got d=%h bout=%b ovfl=%b, expected d=%h bout=%b ovfl=%b",
                             d, bout, ovfl, e.d, e.bout, e.ovfl);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 10) begin
                        n_err++;
                        $display("FAIL b2b_interval: got %0d clocks, expected 10", cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (ready === 1'b1) begin
                if (pushed < 4) begin
                    a     = va[pushed];
                    b     = vb[pushed];
                    start = 1'b1;
                    sb_q.push_back(model(va[pushed], vb[pushed]));
                    pushed++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (got != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results, expected 4", got);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        done_count = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_sub8
`default_nettype wire
